// File: rtl/ft_tx_arbiter.sv
// Round-robin scheduler of telemetry packets and status snapshots onto the 16-bit FT UI TX port.
// Optional CRC-16-CCITT trailer word per frame when FT_TX_CRC_EN is defined.
module ft_tx_arbiter #(
  parameter int          PKT_WIDTH  = 88,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] PKT_HDR    = 16'hA55A,
  parameter logic [15:0] STAT_HDR   = 16'hC33C
) (
  input  logic                 clk_128M,
  input  logic                 rst_128M,
  input  logic [PKT_WIDTH-1:0] pkt_data,
  input  logic                 pkt_valid,
  input  logic                 stat_req,
  input  logic [31:0]          total_packets,
  input  logic [31:0]          mismatch_packets,
  output logic [15:0]          ui_din,
  output logic [1:0]           ui_din_be,
  output logic                 ui_din_valid,
  input  logic                 ui_din_full,
  output logic [15:0]          pkt_drop_count,
  output logic                 busy
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          BODY_W  = 96;
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic        G_PKT   = 1'b0;
  localparam logic        G_STAT  = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_CRC} state_t;

  state_t               state;
  logic                 last_grant;
  logic                 stat_pend;
  logic [PKT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [BODY_W-1:0]    frame_body;
  logic [2:0]           body_left;
  logic [15:0]          din_r;
  logic                 din_vld_r;
  logic                 busy_r;
  logic [15:0]          drop_r;

  logic fifo_empty, fifo_full, grant_pkt, grant_stat, push, pop, beat;

`ifdef FT_TX_CRC_EN
  logic [15:0] crc_r;
  logic [15:0] crc_nx;

  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  assign crc_nx = crc16_word(crc_r, din_r);
`endif

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Round-robin only matters when both sources are waiting: the one not served last wins.
  assign grant_pkt  = (state == S_IDLE) && !fifo_empty && (!stat_pend || last_grant == G_STAT);
  assign grant_stat = (state == S_IDLE) && stat_pend && (fifo_empty || last_grant == G_PKT);
  assign pop        = grant_pkt;
  assign push       = pkt_valid && (!fifo_full || pop);
  assign beat       = din_vld_r && !ui_din_full;

  assign ui_din         = din_r;
  assign ui_din_valid   = din_vld_r;
  assign ui_din_be      = {2{din_vld_r}};
  assign pkt_drop_count = drop_r;
  assign busy           = busy_r;

  always_ff @(posedge clk_128M) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= pkt_data;
  end

  // Frame payload: loaded at grant, shifted one word per transferred body word.
  always_ff @(posedge clk_128M) begin
    if (grant_pkt) begin
      frame_body <= {{(BODY_W-PKT_WIDTH){1'b0}}, fifo_mem[rd_ptr[AW-1:0]]};
      body_left  <= 3'd6;
    end else if (grant_stat) begin
      frame_body <= {32'h0, mismatch_packets, total_packets};
      body_left  <= 3'd4;
    end else if (beat && (state == S_HDR || state == S_BODY)) begin
      frame_body <= {16'h0, frame_body[BODY_W-1:16]};
      if (state == S_BODY) body_left <= body_left - 3'd1;
    end
`ifdef FT_TX_CRC_EN
    if (grant_pkt || grant_stat) crc_r <= 16'hFFFF;
    else if (beat && state == S_BODY) crc_r <= crc_nx;
`endif
  end

  always_ff @(posedge clk_128M) begin
    if (rst_128M) begin
      state      <= S_IDLE;
      last_grant <= G_STAT;
      stat_pend  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      din_r      <= 16'h0000;
      din_vld_r  <= 1'b0;
      busy_r     <= 1'b0;
      drop_r     <= 16'h0000;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (pkt_valid && !push && drop_r != 16'hFFFF) drop_r <= drop_r + 16'd1;
      // A request arriving in the grant cycle stays pending for the next round.
      if (stat_req)        stat_pend <= 1'b1;
      else if (grant_stat) stat_pend <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_pkt || grant_stat) begin
            state      <= S_HDR;
            din_r      <= grant_pkt ? PKT_HDR : STAT_HDR;
            din_vld_r  <= 1'b1;
            busy_r     <= 1'b1;
            last_grant <= grant_pkt ? G_PKT : G_STAT;
          end
        end
        S_HDR: begin
          if (beat) begin
            din_r <= frame_body[15:0];
            state <= S_BODY;
          end
        end
        S_BODY: begin
          if (beat) begin
            if (body_left == 3'd1) begin
`ifdef FT_TX_CRC_EN
              din_r <= crc_nx;
              state <= S_CRC;
`else
              din_r     <= 16'h0000;
              din_vld_r <= 1'b0;
              busy_r    <= 1'b0;
              state     <= S_IDLE;
`endif
            end else begin
              din_r <= frame_body[15:0];
            end
          end
        end
        S_CRC: begin
          if (beat) begin
            din_r     <= 16'h0000;
            din_vld_r <= 1'b0;
            busy_r    <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Scoreboard bench for ft_tx_arbiter: expected words are queued as stimulus is driven
// and compared on every transferred beat; define FT_TX_CRC_EN to exercise the trailer.
module tb_ft_tx_arbiter;

  logic        clk_128M = 1'b0;
  logic        rst_128M = 1'b1;
  logic [87:0] pkt_data = '0;
  logic        pkt_valid = 1'b0;
  logic        stat_req = 1'b0;
  logic [31:0] total_packets = '0;
  logic [31:0] mismatch_packets = '0;
  logic [15:0] ui_din;
  logic [1:0]  ui_din_be;
  logic        ui_din_valid;
  logic        ui_din_full = 1'b0;
  logic [15:0] pkt_drop_count;
  logic        busy;

  ft_tx_arbiter dut (
    .clk_128M(clk_128M), .rst_128M(rst_128M), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
    .stat_req(stat_req), .total_packets(total_packets), .mismatch_packets(mismatch_packets),
    .ui_din(ui_din), .ui_din_be(ui_din_be), .ui_din_valid(ui_din_valid),
    .ui_din_full(ui_din_full), .pkt_drop_count(pkt_drop_count), .busy(busy)
  );

  always #5 clk_128M = ~clk_128M;

`ifdef FT_TX_CRC_EN
  localparam int FLEN_PKT  = 8;
  localparam int FLEN_STAT = 6;
`else
  localparam int FLEN_PKT  = 7;
  localparam int FLEN_STAT = 5;
`endif

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          beats = 0;
  int          beat_cyc_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] prev_din = '0;
  logic        prev_hold = 1'b0;
  logic        model_last_stat = 1'b1;

  always @(posedge clk_128M) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Beat monitor: sampled mid-cycle so ui_din_full is the value the next edge will see.
  always @(negedge clk_128M) begin
    if (rst_128M) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_din", 32'(ui_din), 32'(prev_din));
        check("hold_valid", 32'(ui_din_valid), 1);
      end
      if (ui_din_valid && !ui_din_full) begin
        beats++;
        beat_cyc_q.push_back(cyc);
        check("be", 32'(ui_din_be), 3);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_word: got %h required no word (cycle %0d)", ui_din, cyc);
        end else begin
          check("word", 32'(ui_din), 32'(exp_q.pop_front()));
        end
      end
      prev_hold = ui_din_valid && ui_din_full;
      prev_din  = ui_din;
    end
  end

  task automatic push_frame(input logic [15:0] hdr, input logic [15:0] body[6], input int len);
`ifdef FT_TX_CRC_EN
    logic [15:0] crc;
    logic        fb;
    crc = 16'hFFFF;
`endif
    exp_q.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(body[i]);
`ifdef FT_TX_CRC_EN
      for (int b = 15; b >= 0; b--) begin
        fb  = crc[15] ^ body[i][b];
        crc = crc << 1;
        if (fb) crc = crc ^ 16'h1021;
      end
`endif
    end
`ifdef FT_TX_CRC_EN
    exp_q.push_back(crc);
`endif
  endtask

  task automatic push_pkt(input logic [87:0] p);
    logic [15:0] b[6];
    b[0] = p[15:0];  b[1] = p[31:16]; b[2] = p[47:32];
    b[3] = p[63:48]; b[4] = p[79:64]; b[5] = {8'h00, p[87:80]};
    push_frame(16'hA55A, b, 6);
  endtask

  task automatic push_stat(input logic [31:0] t, input logic [31:0] m);
    logic [15:0] b[6];
    b[0] = t[15:0]; b[1] = t[31:16]; b[2] = m[15:0]; b[3] = m[31:16];
    b[4] = 16'h0;   b[5] = 16'h0;
    push_frame(16'hC33C, b, 4);
  endtask

  task automatic tick();
    @(posedge clk_128M);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  task automatic send_pkt(input logic [87:0] p);
    pkt_data  = p;
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy || ui_din_valid) && k < 400) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k >= 400) begin
      n_bad++;
      $display("FAIL %s_timeout: %0d words still expected, busy=%0b", name, exp_q.size(), busy);
      exp_q.delete();
    end
    tick();
  endtask

  typedef struct {
    logic        do_pkt;
    logic        do_stat;
    logic [87:0] pkt;
    logic [31:0] tot;
    logic [31:0] mis;
  } vec_t;

  vec_t vt[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n, base;
    logic busy_log[16];
    logic [87:0] p4, p6;

    for (int i = 0; i < 16; i++) busy_log[i] = 1'b0;
    vt[0] = '{1'b1, 1'b1, 88'h11_2233_4455_6677_8899_AABB, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    vt[1] = '{1'b1, 1'b1, 88'hC0_FFEE_1234_5678_9ABC_DEF0, 32'h0000_0001, 32'h8000_0000};
    vt[2] = '{1'b1, 1'b0, 88'hFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0, 32'h0};
    vt[3] = '{1'b0, 1'b1, 88'h0, 32'hFFFF_FFFF, 32'h1357_9BDF};

    repeat (3) tick();
    check("rst_din", 32'(ui_din), 0);
    check("rst_valid", 32'(ui_din_valid), 0);
    check("rst_be", 32'(ui_din_be), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(pkt_drop_count), 0);
    rst_128M = 1'b0;
    repeat (2) tick();

    // Single packet: latency and busy window
    beat_cyc_q.delete();
    push_pkt(88'h0A_0908_0706_0504_0302_0100);
    n = cyc;
    send_pkt(88'h0A_0908_0706_0504_0302_0100);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_128M);
      if (cyc - n >= 0 && cyc - n < 16) busy_log[cyc - n] = busy;
    end
    tick();
    wait_idle("pkt1");
    model_last_stat = 1'b0;
    check("pkt1_len", beat_cyc_q.size(), FLEN_PKT);
    check("pkt1_hdr_cyc", beat_cyc_q[0], n + 2);
    check("pkt1_last_body_cyc", beat_cyc_q[6], n + 8);
    check("pkt1_busy_hdr", 32'(busy_log[2]), 1);
    check("pkt1_busy_last", 32'(busy_log[8]), 1);
    check("pkt1_busy_after", 32'(busy_log[FLEN_PKT + 2]), 0);

    // Status frame; counters changed after the grant must not leak in
    total_packets    = 32'h0001_2345;
    mismatch_packets = 32'h0000_0007;
    base = beats;
    push_stat(32'h0001_2345, 32'h0000_0007);
    n = cyc;
    stat_req = 1'b1;
    tick();
    stat_req = 1'b0;
    goto(n + 2);
    total_packets    = 32'hFFFF_FFFF;
    mismatch_packets = 32'hAAAA_5555;
    wait_idle("stat1");
    model_last_stat = 1'b1;
    check("stat1_len", beats - base, FLEN_STAT);

    // Table: simultaneous and single requests, round-robin order
    for (int v = 0; v < 4; v++) begin
      if (vt[v].do_pkt && vt[v].do_stat) begin
        if (model_last_stat) begin
          push_pkt(vt[v].pkt); push_stat(vt[v].tot, vt[v].mis); model_last_stat = 1'b1;
        end else begin
          push_stat(vt[v].tot, vt[v].mis); push_pkt(vt[v].pkt); model_last_stat = 1'b0;
        end
      end else if (vt[v].do_pkt) begin
        push_pkt(vt[v].pkt); model_last_stat = 1'b0;
      end else begin
        push_stat(vt[v].tot, vt[v].mis); model_last_stat = 1'b1;
      end
      pkt_data         = vt[v].pkt;
      total_packets    = vt[v].tot;
      mismatch_packets = vt[v].mis;
      pkt_valid        = vt[v].do_pkt;
      stat_req         = vt[v].do_stat;
      tick();
      pkt_valid = 1'b0;
      stat_req  = 1'b0;
      wait_idle("table");
    end

    // Backpressure on the third body word
    p4   = 88'h5A_A5A5_1111_2222_3333_4444;
    base = beats;
    push_pkt(p4);
    n = cyc;
    send_pkt(p4);
    goto(n + 5);
    ui_din_full = 1'b1;
    check("bp_word_start", 32'(ui_din), 32'(p4[47:32]));
    repeat (5) tick();
    check("bp_word_end", 32'(ui_din), 32'(p4[47:32]));
    check("bp_valid_end", 32'(ui_din_valid), 1);
    ui_din_full = 1'b0;
    wait_idle("bp");
    check("bp_len", beats - base, FLEN_PKT);

    // Overflow while the port is blocked: 1 in frame register, 4 buffered, 2 dropped
    ui_din_full = 1'b1;
    base = beats;
    for (int k = 0; k < 7; k++) begin
      if (k < 5) push_pkt({8'(k + 1), 80'h0F0E_0D0C_0B0A_0908_0706} ^ {88{k[0]}});
      send_pkt({8'(k + 1), 80'h0F0E_0D0C_0B0A_0908_0706} ^ {88{k[0]}});
    end
    tick();
    check("ovf_drop", 32'(pkt_drop_count), 2);
    ui_din_full = 1'b0;
    wait_idle("ovf");
    check("ovf_len", beats - base, 5 * FLEN_PKT);
    model_last_stat = 1'b0;

    // Reset mid-body: frame aborted, queued packet flushed
    p6 = 88'h77_6655_4433_2211_00FF_EEDD;
    exp_q.push_back(16'hA55A);
    exp_q.push_back(p6[15:0]);
    exp_q.push_back(p6[31:16]);
    n = cyc;
    send_pkt(p6);
    send_pkt(88'h99_8877_6655_4433_2211_0000);
    goto(n + 5);
    rst_128M = 1'b1;
    tick();
    check("abort_valid", 32'(ui_din_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_drop", 32'(pkt_drop_count), 0);
    rst_128M = 1'b0;
    repeat (12) tick();
    check("abort_drained", exp_q.size(), 0);
    check("abort_quiet", 32'(ui_din_valid), 0);
    base = beats;
    push_pkt(88'h12_3456_789A_BCDE_F012_3456);
    send_pkt(88'h12_3456_789A_BCDE_F012_3456);
    wait_idle("post_rst");
    check("post_rst_len", beats - base, FLEN_PKT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
